// File: rtl/ttl_checksum_update.sv
// ttl_checksum_update
//
// Sits after the IPv4 header-checksum stage. For each IPv4 packet it checks
// the folded header sum, decrements TTL, and patches the header checksum
// incrementally. Packets with a bad checksum or an expiring TTL are dropped
// and counted. Non-IPv4 frames and single-beat frames pass through untouched.
//
// Ports
//   AXI_ACLK, AXI_RESET      clock, synchronous active-high reset
//   S_AXIS_*                 input stream (TDATA/TSTRB/TUSER/TVALID/TLAST, TREADY out)
//   M_AXIS_*                 output stream (TDATA/TSTRB/TUSER/TVALID/TLAST, TREADY in)
//   checksum_final_in[31:0]  unfolded IPv4 header sum for the current packet
//   low_ip_addr_in[15:0]     destination IP [15:0] for the current packet
//   ip_dst_out, ip_dst_valid full destination IP, one-cycle pulse per header sent
//   bad_csum_count           packets dropped for a bad header checksum
//   ttl_exp_count            packets dropped for TTL <= 1
module ttl_checksum_update #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESET,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,

    input  logic [31:0]                         checksum_final_in,
    input  logic [15:0]                         low_ip_addr_in,

    output logic [31:0]                         ip_dst_out,
    output logic                                ip_dst_valid,
    output logic [31:0]                         bad_csum_count,
    output logic [31:0]                         ttl_exp_count
);

    localparam int SDW = C_S_AXIS_DATA_WIDTH;
    localparam int SKW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int SUW = C_S_AXIS_TUSER_WIDTH;
    localparam int MDW = C_M_AXIS_DATA_WIDTH;
    localparam int MKW = C_M_AXIS_DATA_WIDTH / 8;
    localparam int MUW = C_M_AXIS_TUSER_WIDTH;

    typedef enum logic [2:0] {
        WAIT_HDR,
        FOLD1,
        FOLD2,
        SEND_HDR,
        PAYLOAD,
        DROP,
        BYPASS
    } state_t;

    // First fold of the 32-bit sum: high half plus low half, keeping the carry.
    function automatic logic [16:0] fold_halves(input logic [31:0] sum);
        return {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
    endfunction

    // Add the carry bit back in (end-around carry). Cannot overflow again
    // because the 17-bit input is at most 0x1FFFE.
    function automatic logic [15:0] end_around(input logic [16:0] s);
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        return end_around({1'b0, a} + {1'b0, b});
    endfunction

    state_t           state_q, state_d;

    logic [SDW-1:0]   hold_data_q;
    logic [SKW-1:0]   hold_strb_q;
    logic [SUW-1:0]   hold_user_q;
    logic             hold_last_q;

    logic [MDW-1:0]   m_data_q;
    logic [MKW-1:0]   m_strb_q;
    logic [MUW-1:0]   m_user_q;
    logic             m_last_q;
    logic             m_valid_q;

    logic [16:0]      s1_q;
    logic [15:0]      low_ip_q;
    logic [31:0]      ip_dst_q;
    logic             ip_dst_valid_q;
    logic [31:0]      bad_cnt_q;
    logic [31:0]      ttl_cnt_q;

    logic             out_free;
    logic             s_ready;
    logic             is_ipv4_hdr;
    logic [15:0]      s2;
    logic [7:0]       hold_ttl;
    logic [15:0]      hold_csum;

    logic             capture_hold;
    logic             load_from_in;
    logic             load_from_hold;
    logic             patch_hdr;
    logic             bad_inc;
    logic             ttl_inc;

    // The output register can take a new beat this cycle if it is empty or
    // its current beat is being accepted downstream right now.
    assign out_free    = !m_valid_q || M_AXIS_TREADY;
    assign is_ipv4_hdr = !S_AXIS_TLAST
                      && (S_AXIS_TDATA[159:144] == 16'h0800)
                      && (S_AXIS_TDATA[143:136] == 8'h45);
    assign s2          = end_around(s1_q);
    assign hold_ttl    = hold_data_q[79:72];
    assign hold_csum   = hold_data_q[63:48];

    always_comb begin
        state_d        = state_q;
        s_ready        = 1'b0;
        capture_hold   = 1'b0;
        load_from_in   = 1'b0;
        load_from_hold = 1'b0;
        patch_hdr      = 1'b0;
        bad_inc        = 1'b0;
        ttl_inc        = 1'b0;

        case (state_q)
            WAIT_HDR: begin
                s_ready = out_free;
                if (S_AXIS_TVALID && out_free) begin
                    capture_hold = 1'b1;
                    if (is_ipv4_hdr) begin
                        state_d = FOLD1;
                    end else begin
                        // Not ours to modify: forward beat 0 straight away.
                        load_from_in = 1'b1;
                        state_d      = S_AXIS_TLAST ? WAIT_HDR : BYPASS;
                    end
                end
            end
            FOLD1: begin
                state_d = FOLD2;
            end
            FOLD2: begin
                // A bad checksum outranks an expiring TTL; only one counter moves.
                if (s2 != 16'hFFFF) begin
                    bad_inc = 1'b1;
                    state_d = DROP;
                end else if (hold_ttl <= 8'd1) begin
                    ttl_inc = 1'b1;
                    state_d = DROP;
                end else begin
                    patch_hdr = 1'b1;
                    state_d   = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (out_free) begin
                    load_from_hold = 1'b1;
                    state_d        = PAYLOAD;
                end
            end
            PAYLOAD, BYPASS: begin
                s_ready = out_free;
                if (S_AXIS_TVALID && out_free) begin
                    load_from_in = 1'b1;
                    if (S_AXIS_TLAST) begin
                        state_d = WAIT_HDR;
                    end
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (S_AXIS_TVALID && S_AXIS_TLAST) begin
                    state_d = WAIT_HDR;
                end
            end
            default: begin
                state_d = WAIT_HDR;
            end
        endcase
    end

    assign S_AXIS_TREADY = s_ready && !AXI_RESET;

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q        <= WAIT_HDR;
            hold_data_q    <= '0;
            hold_strb_q    <= '0;
            hold_user_q    <= '0;
            hold_last_q    <= 1'b0;
            m_data_q       <= '0;
            m_strb_q       <= '0;
            m_user_q       <= '0;
            m_last_q       <= 1'b0;
            m_valid_q      <= 1'b0;
            s1_q           <= '0;
            low_ip_q       <= '0;
            ip_dst_q       <= '0;
            ip_dst_valid_q <= 1'b0;
            bad_cnt_q      <= '0;
            ttl_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            ip_dst_valid_q <= 1'b0;

            if (capture_hold) begin
                hold_data_q <= S_AXIS_TDATA;
                hold_strb_q <= S_AXIS_TSTRB;
                hold_user_q <= S_AXIS_TUSER;
                hold_last_q <= S_AXIS_TLAST;
            end

            // Side inputs become valid the cycle after the beat-0 handshake.
            if (state_q == FOLD1) begin
                s1_q     <= fold_halves(checksum_final_in);
                low_ip_q <= low_ip_addr_in;
            end

            // TTL is the high byte of its 16-bit header word, so decrementing
            // it lowers the word by 0x0100; the checksum rises by the same amount.
            if (patch_hdr) begin
                hold_data_q[79:72] <= hold_ttl - 8'd1;
                hold_data_q[63:48] <= ones_add(hold_csum, 16'h0100);
            end

            if (load_from_in) begin
                m_data_q  <= MDW'(S_AXIS_TDATA);
                m_strb_q  <= MKW'(S_AXIS_TSTRB);
                m_user_q  <= MUW'(S_AXIS_TUSER);
                m_last_q  <= S_AXIS_TLAST;
                m_valid_q <= 1'b1;
            end else if (load_from_hold) begin
                m_data_q       <= MDW'(hold_data_q);
                m_strb_q       <= MKW'(hold_strb_q);
                m_user_q       <= MUW'(hold_user_q);
                m_last_q       <= hold_last_q;
                m_valid_q      <= 1'b1;
                ip_dst_q       <= {hold_data_q[15:0], low_ip_q};
                ip_dst_valid_q <= 1'b1;
            end else if (M_AXIS_TREADY) begin
                m_valid_q <= 1'b0;
            end

            if (bad_inc) begin
                bad_cnt_q <= bad_cnt_q + 32'd1;
            end
            if (ttl_inc) begin
                ttl_cnt_q <= ttl_cnt_q + 32'd1;
            end
        end
    end

    assign M_AXIS_TDATA   = m_data_q;
    assign M_AXIS_TSTRB   = m_strb_q;
    assign M_AXIS_TUSER   = m_user_q;
    assign M_AXIS_TLAST   = m_last_q;
    assign M_AXIS_TVALID  = m_valid_q;
    assign ip_dst_out     = ip_dst_q;
    assign ip_dst_valid   = ip_dst_valid_q;
    assign bad_csum_count = bad_cnt_q;
    assign ttl_exp_count  = ttl_cnt_q;

endmodule

// File: tb/tb_ttl_checksum_update.sv
module tb_ttl_checksum_update;

    logic         clk = 1'b0;
    logic         AXI_RESET;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TREADY;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic [31:0]  checksum_final_in;
    logic [15:0]  low_ip_addr_in;
    logic [31:0]  ip_dst_out;
    logic         ip_dst_valid;
    logic [31:0]  bad_csum_count;
    logic [31:0]  ttl_exp_count;

    ttl_checksum_update dut (
        .AXI_ACLK          (clk),
        .AXI_RESET         (AXI_RESET),
        .S_AXIS_TDATA      (S_AXIS_TDATA),
        .S_AXIS_TSTRB      (S_AXIS_TSTRB),
        .S_AXIS_TUSER      (S_AXIS_TUSER),
        .S_AXIS_TVALID     (S_AXIS_TVALID),
        .S_AXIS_TLAST      (S_AXIS_TLAST),
        .S_AXIS_TREADY     (S_AXIS_TREADY),
        .M_AXIS_TDATA      (M_AXIS_TDATA),
        .M_AXIS_TSTRB      (M_AXIS_TSTRB),
        .M_AXIS_TUSER      (M_AXIS_TUSER),
        .M_AXIS_TVALID     (M_AXIS_TVALID),
        .M_AXIS_TLAST      (M_AXIS_TLAST),
        .M_AXIS_TREADY     (M_AXIS_TREADY),
        .checksum_final_in (checksum_final_in),
        .low_ip_addr_in    (low_ip_addr_in),
        .ip_dst_out        (ip_dst_out),
        .ip_dst_valid      (ip_dst_valid),
        .bad_csum_count    (bad_csum_count),
        .ttl_exp_count     (ttl_exp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t        expq[$];
    logic [31:0]  ipq[$];
    int           checks = 0;
    int           errors = 0;

    logic [255:0] pd[4];
    logic [31:0]  ps[4];
    logic [127:0] pu[4];
    logic [255:0] exp0;
    int           lat;
    bit           rdy_toggle = 1'b0;

    localparam int FWD = 0;
    localparam int MOD = 1;
    localparam int DRP = 2;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] set_hdr(input logic [255:0] base, input logic [15:0] et,
                                             input logic [7:0] vi, input logic [7:0] ttl,
                                             input logic [15:0] cs, input logic [15:0] dh);
        logic [255:0] r;
        r = base;
        r[159:144] = et;
        r[143:136] = vi;
        r[79:72]   = ttl;
        r[63:48]   = cs;
        r[15:0]    = dh;
        return r;
    endfunction

    // Downstream ready: held high, or 50% random when toggling.
    always @(posedge clk) begin
        #1;
        if (rdy_toggle) M_AXIS_TREADY = 1'($urandom % 2);
    end

    // Output monitor, evaluated mid-cycle: a beat seen with VALID&&READY here
    // transfers on the next rising edge.
    logic         prev_stall = 1'b0;
    logic         prev_rst   = 1'b0;
    logic [255:0] prev_d;
    logic [31:0]  prev_s;
    logic [127:0] prev_u;
    logic         prev_l;

    always @(negedge clk) begin
        beat_t e;
        if (prev_stall && !prev_rst) begin
            checks++;
            if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_d || M_AXIS_TSTRB !== prev_s ||
                M_AXIS_TUSER !== prev_u || M_AXIS_TLAST !== prev_l) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h required data=%h", M_AXIS_TVALID,
                         M_AXIS_TDATA, prev_d);
            end
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL out_beat: unexpected beat data=%h, none required", M_AXIS_TDATA);
            end else begin
                e = expq.pop_front();
                if (M_AXIS_TDATA !== e.d || M_AXIS_TSTRB !== e.s || M_AXIS_TUSER !== e.u ||
                    M_AXIS_TLAST !== e.l) begin
                    errors++;
                    $display("FAIL out_beat: data=%h strb=%h last=%b required data=%h strb=%h last=%b",
                             M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, e.d, e.s, e.l);
                end
            end
        end
        if (ip_dst_valid) begin
            checks++;
            if (ipq.size() == 0) begin
                errors++;
                $display("FAIL ip_dst: unexpected pulse ip=%h, none required", ip_dst_out);
            end else begin
                logic [31:0] ei;
                ei = ipq.pop_front();
                if (ip_dst_out !== ei) begin
                    errors++;
                    $display("FAIL ip_dst: got %h required %h", ip_dst_out, ei);
                end
            end
        end
        prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_rst   = AXI_RESET;
        prev_d     = M_AXIS_TDATA;
        prev_s     = M_AXIS_TSTRB;
        prev_u     = M_AXIS_TUSER;
        prev_l     = M_AXIS_TLAST;
    end

    task automatic drive_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                              input logic l, output bit ok);
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TSTRB  = s;
        S_AXIS_TUSER  = u;
        S_AXIS_TLAST  = l;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (S_AXIS_TREADY) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic fill_pkt(input int n);
        for (int k = 0; k < n; k++) begin
            pd[k] = rand256();
            ps[k] = (k == n - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            pu[k] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic send_pkt(input int n, input int mode, input int nsend, input bit meas);
        bit ok;
        beat_t b;
        for (int k = 0; k < nsend; k++) begin
            drive_beat(pd[k], ps[k], pu[k], (k == n - 1), ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL beat_accept: beat %0d never accepted, required acceptance", k);
                return;
            end
            if (mode != DRP) begin
                b.d = (mode == MOD && k == 0) ? exp0 : pd[k];
                b.s = ps[k];
                b.u = pu[k];
                b.l = (k == n - 1);
                expq.push_back(b);
                if (mode == MOD && k == 0) ipq.push_back({pd[0][15:0], low_ip_addr_in});
            end
            if (meas && k == 0) begin
                lat = 0;
                while (!M_AXIS_TVALID && lat < 10) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((expq.size() != 0 || M_AXIS_TVALID) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (expq.size() != 0 || ipq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: beats left %0d ip left %0d, required 0 and 0", nm,
                     expq.size(), ipq.size());
        end
    endtask

    task automatic check_counts(input string nm, input logic [31:0] eb, input logic [31:0] et);
        checks++;
        if (bad_csum_count !== eb || ttl_exp_count !== et) begin
            errors++;
            $display("FAIL %s_counts: bad=%0d ttl=%0d required bad=%0d ttl=%0d", nm,
                     bad_csum_count, ttl_exp_count, eb, et);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || S_AXIS_TREADY !== 1'b0 || ip_dst_valid !== 1'b0 ||
            ip_dst_out !== 32'd0 || bad_csum_count !== 32'd0 || ttl_exp_count !== 32'd0) begin
            errors++;
            $display("FAIL %s: tvalid=%b tready=%b ipv=%b ip=%h bad=%0d ttl=%0d required all zero",
                     nm, M_AXIS_TVALID, S_AXIS_TREADY, ip_dst_valid, ip_dst_out, bad_csum_count,
                     ttl_exp_count);
        end
    endtask

    task automatic test_reset();
        AXI_RESET = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        AXI_RESET = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (S_AXIS_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready: got %b required 1", S_AXIS_TREADY);
        end
    endtask

    task automatic test_ipv4_basic();
        logic [255:0] base;
        fill_pkt(3);
        base = rand256();
        checksum_final_in = 32'h0002_FFFD;
        low_ip_addr_in    = 16'h1234;
        pd[0] = set_hdr(base, 16'h0800, 8'h45, 8'h40, 16'hB1E6, 16'hC0A8);
        exp0  = set_hdr(base, 16'h0800, 8'h45, 8'h3F, 16'hB2E6, 16'hC0A8);
        send_pkt(3, MOD, 3, 1'b1);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL hdr_latency: got %0d cycles required 3", lat);
        end
        wait_drain("ipv4_basic");
        check_counts("ipv4_basic", 32'd0, 32'd0);
    endtask

    task automatic test_csum_wrap();
        logic [255:0] base;
        fill_pkt(2);
        base = rand256();
        low_ip_addr_in = 16'hBEEF;
        pd[0] = set_hdr(base, 16'h0800, 8'h45, 8'h05, 16'hFF00, 16'h0A00);
        exp0  = set_hdr(base, 16'h0800, 8'h45, 8'h04, 16'h0001, 16'h0A00);
        send_pkt(2, MOD, 2, 1'b0);
        wait_drain("csum_wrap");
        check_counts("csum_wrap", 32'd0, 32'd0);
    endtask

    task automatic test_bad_csum();
        fill_pkt(3);
        checksum_final_in = 32'h0001_FFFD;
        pd[0] = set_hdr(pd[0], 16'h0800, 8'h45, 8'h40, 16'h1111, 16'h0102);
        send_pkt(3, DRP, 3, 1'b0);
        wait_drain("bad_csum");
        check_counts("bad_csum", 32'd1, 32'd0);
    endtask

    task automatic test_ttl_expire();
        checksum_final_in = 32'h0002_FFFD;
        fill_pkt(2);
        pd[0] = set_hdr(pd[0], 16'h0800, 8'h45, 8'h01, 16'h2222, 16'h0304);
        send_pkt(2, DRP, 2, 1'b0);
        wait_drain("ttl_one");
        check_counts("ttl_one", 32'd1, 32'd1);
        fill_pkt(3);
        pd[0] = set_hdr(pd[0], 16'h0800, 8'h45, 8'h00, 16'h3333, 16'h0506);
        send_pkt(3, DRP, 3, 1'b0);
        wait_drain("ttl_zero");
        check_counts("ttl_zero", 32'd1, 32'd2);
    endtask

    task automatic test_bypass();
        fill_pkt(3);
        pd[0] = set_hdr(pd[0], 16'h0806, 8'h45, 8'h40, 16'hB1E6, 16'h0708);
        send_pkt(3, FWD, 3, 1'b0);
        wait_drain("bypass_arp");
        fill_pkt(1);
        pd[0] = set_hdr(pd[0], 16'h0800, 8'h45, 8'h40, 16'hB1E6, 16'h090A);
        send_pkt(1, FWD, 1, 1'b0);
        wait_drain("bypass_single");
        fill_pkt(2);
        pd[0] = set_hdr(pd[0], 16'h0800, 8'h46, 8'h40, 16'hB1E6, 16'h0B0C);
        send_pkt(2, FWD, 2, 1'b0);
        wait_drain("bypass_ihl");
        check_counts("bypass", 32'd1, 32'd2);
    endtask

    task automatic test_back_to_back();
        logic [255:0] base;
        rdy_toggle = 1'b1;
        checksum_final_in = 32'h0002_FFFD;
        for (int p = 0; p < 4; p++) begin
            fill_pkt(4);
            base = rand256();
            low_ip_addr_in = 16'(p * 16'h1111 + 16'h0F0F);
            pd[0] = set_hdr(base, 16'h0800, 8'h45, 8'(8'h10 + p), 16'h4000, 16'(16'hA000 + p));
            exp0  = set_hdr(base, 16'h0800, 8'h45, 8'(8'h0F + p), 16'h4100, 16'(16'hA000 + p));
            send_pkt(4, MOD, 4, 1'b0);
            fill_pkt(2);
            pd[0] = set_hdr(pd[0], 16'h86DD, 8'h60, 8'h00, 16'h0000, 16'h0000);
            send_pkt(2, FWD, 2, 1'b0);
        end
        rdy_toggle = 1'b0;
        M_AXIS_TREADY = 1'b1;
        wait_drain("back_to_back");
        check_counts("back_to_back", 32'd1, 32'd2);
    endtask

    task automatic test_reset_mid();
        logic [255:0] base;
        rdy_toggle = 1'b1;
        fill_pkt(4);
        base = rand256();
        low_ip_addr_in = 16'h5555;
        pd[0] = set_hdr(base, 16'h0800, 8'h45, 8'h20, 16'h1234, 16'h6666);
        exp0  = set_hdr(base, 16'h0800, 8'h45, 8'h1F, 16'h1334, 16'h6666);
        send_pkt(4, MOD, 3, 1'b0);
        AXI_RESET = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_state");
        expq.delete();
        ipq.delete();
        rdy_toggle = 1'b0;
        M_AXIS_TREADY = 1'b1;
        @(posedge clk);
        #1;
        AXI_RESET = 1'b0;
        fill_pkt(2);
        base = rand256();
        low_ip_addr_in = 16'h7777;
        pd[0] = set_hdr(base, 16'h0800, 8'h45, 8'h80, 16'hFFFE, 16'h8888);
        exp0  = set_hdr(base, 16'h0800, 8'h45, 8'h7F, 16'h00FF, 16'h8888);
        send_pkt(2, MOD, 2, 1'b0);
        wait_drain("reset_mid_next");
        check_counts("reset_mid_next", 32'd0, 32'd0);
    endtask

    initial begin
        AXI_RESET         = 1'b1;
        S_AXIS_TDATA      = '0;
        S_AXIS_TSTRB      = '0;
        S_AXIS_TUSER      = '0;
        S_AXIS_TVALID     = 1'b0;
        S_AXIS_TLAST      = 1'b0;
        M_AXIS_TREADY     = 1'b1;
        checksum_final_in = '0;
        low_ip_addr_in    = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_ipv4_basic();
        test_csum_wrap();
        test_bad_csum();
        test_ttl_expire();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
